// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and small burst helpers used by the subordinate
// front-end and its burst address calculator.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3,
    HSIZE_4W    = 3'd4,
    HSIZE_8W    = 3'd5,
    HSIZE_16W   = 3'd6,
    HSIZE_32W   = 3'd7
  } hsize_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ERR1   = 2'd2,
    ST_ERR2   = 2'd3
  } state_e;

  // Number of beats in a burst; 0 means undefined-length INCR.
  function automatic logic [4:0] burst_len(input logic [2:0] burst);
    logic [4:0] len;
    case (burst)
      HBURST_SINGLE:                len = 5'd1;
      HBURST_INCR:                  len = 5'd0;
      HBURST_WRAP4, HBURST_INCR4:   len = 5'd4;
      HBURST_WRAP8, HBURST_INCR8:   len = 5'd8;
      default:                      len = 5'd16;
    endcase
    return len;
  endfunction

  function automatic logic burst_is_wrap(input logic [2:0] burst);
    return (burst == HBURST_WRAP4) || (burst == HBURST_WRAP8) ||
           (burst == HBURST_WRAP16);
  endfunction

endpackage

// File: rtl/ahb_burst_addr.sv
// Combinational next-beat address for an open burst, plus the wrap window mask
// (zero for incrementing bursts).
module ahb_burst_addr
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] prev_addr,
  input  logic [2:0]            size,
  input  logic [2:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic [ADDR_WIDTH-1:0] wrap_mask
);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] span;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic                  is_wrap;

  assign step      = ADDR_WIDTH'(1) << size;
  assign span      = ADDR_WIDTH'(burst_len(burst)) << size;
  assign is_wrap   = burst_is_wrap(burst);
  assign wrap_mask = is_wrap ? (span - ADDR_WIDTH'(1)) : '0;
  assign incr_addr = prev_addr + step;

  // Wrapping bursts keep the upper bits and let only the in-window offset roll over.
  assign next_addr = is_wrap ? ((prev_addr & ~wrap_mask) | (incr_addr & wrap_mask))
                             : incr_addr;

endmodule

// File: rtl/ahb_slave_if.sv
// AHB-Lite subordinate front-end: each accepted beat becomes a local valid/ready
// request; protocol violations and local errors produce a two-cycle ERROR.
module ahb_slave_if
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  valid,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  write,
  output logic [2:0]            size,
  output logic [2:0]            burst,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  slave_error
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

  state_e                state_reg, state_next;
  logic                  valid_reg, valid_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic                  write_reg, write_next;
  logic [2:0]            size_reg, size_next;
  logic [2:0]            burst_reg, burst_next;
  logic [DATA_WIDTH-1:0] hrdata_reg, hrdata_next;
  logic                  open_reg, open_next;
  logic [4:0]            beat_cnt_reg, beat_cnt_next;

  logic [ADDR_WIDTH-1:0] exp_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] align_mask;
  logic                  sample;
  logic                  is_beat;
  logic                  is_nonseq;
  logic                  is_seq;
  logic                  size_bad;
  logic                  align_bad;
  logic                  wrap_escape;
  logic                  seq_bad;
  logic                  beat_ok;
  logic [4:0]            new_cnt;
  logic [4:0]            new_len;

  ahb_burst_addr #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_burst_addr (
    .prev_addr(addr_reg),
    .size     (size_reg),
    .burst    (burst_reg),
    .next_addr(exp_addr),
    .wrap_mask(wrap_mask)
  );

  // Low-order address bits that must be zero for a beat of size hsize.
  for (genvar gi = 0; gi < ADDR_WIDTH; gi++) begin : g_align
    assign align_mask[gi] = (int'(hsize) > gi);
  end

  assign sample      = ((state_reg == ST_IDLE) || (state_reg == ST_ERR2)) && hsel && hready;
  assign is_nonseq   = (htrans == HTRANS_NONSEQ);
  assign is_seq      = (htrans == HTRANS_SEQ);
  assign is_beat     = is_nonseq || is_seq;
  assign size_bad    = (hsize > MAX_SIZE);
  assign align_bad   = |(haddr & align_mask);
  assign wrap_escape = burst_is_wrap(burst_reg) && (|((haddr ^ addr_reg) & ~wrap_mask));
  assign seq_bad     = is_seq && (!open_reg || (haddr != exp_addr) || wrap_escape);
  assign beat_ok     = !(size_bad || align_bad || seq_bad);
  assign new_cnt     = is_nonseq ? 5'd1 : (beat_cnt_reg + 5'd1);
  assign new_len     = is_nonseq ? burst_len(hburst) : burst_len(burst_reg);

  always_comb begin
    state_next    = state_reg;
    valid_next    = valid_reg;
    addr_next     = addr_reg;
    write_next    = write_reg;
    size_next     = size_reg;
    burst_next    = burst_reg;
    hrdata_next   = hrdata_reg;
    open_next     = open_reg;
    beat_cnt_next = beat_cnt_reg;
    case (state_reg)
      ST_IDLE, ST_ERR2: begin
        state_next = ST_IDLE;
        if (sample) begin
          if (is_beat) begin
            if (beat_ok) begin
              state_next    = ST_ACCESS;
              valid_next    = 1'b1;
              addr_next     = haddr;
              write_next    = hwrite;
              size_next     = hsize;
              burst_next    = hburst;
              beat_cnt_next = new_cnt;
              // Fixed-length bursts close on their final beat; INCR stays open.
              open_next     = (new_len == 5'd0) || (new_cnt != new_len);
            end else begin
              state_next = ST_ERR1;
              open_next  = 1'b0;
            end
          end else if (htrans == HTRANS_IDLE) begin
            open_next = 1'b0;
          end
        end
      end
      ST_ACCESS: begin
        if (ready) begin
          valid_next = 1'b0;
          if (slave_error) begin
            state_next = ST_ERR1;
            open_next  = 1'b0;
          end else begin
            state_next = ST_IDLE;
            if (!write_reg) begin
              hrdata_next = rdata;
            end
          end
        end
      end
      ST_ERR1: begin
        state_next = ST_ERR2;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      valid_reg    <= 1'b0;
      addr_reg     <= '0;
      write_reg    <= 1'b0;
      size_reg     <= '0;
      burst_reg    <= '0;
      hrdata_reg   <= '0;
      open_reg     <= 1'b0;
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      valid_reg    <= valid_next;
      addr_reg     <= addr_next;
      write_reg    <= write_next;
      size_reg     <= size_next;
      burst_reg    <= burst_next;
      hrdata_reg   <= hrdata_next;
      open_reg     <= open_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

  // Response signals decode straight from the state register, so ready never
  // reaches hreadyout combinationally.
  assign hreadyout = (state_reg == ST_IDLE) || (state_reg == ST_ERR2);
  assign hresp     = (state_reg == ST_ERR1) || (state_reg == ST_ERR2);
  assign hrdata    = hrdata_reg;
  assign valid     = valid_reg;
  assign addr      = addr_reg;
  assign write     = write_reg;
  assign size      = size_reg;
  assign burst     = burst_reg;
  assign wdata     = hwdata;

endmodule

// File: doc/ahb_slave_if.md
# ahb_slave_if

AHB-Lite subordinate front-end. It accepts AHB address/data-phase transfers from the bus and turns each beat into a local valid/ready request toward a testbench or RTL memory model, with wait states, two-cycle ERROR responses and burst address checking. It is the responder counterpart of the master-side bench interface and sits between the AHB interconnect/decoder and the local slave model.

## Interface
- ADDR_WIDTH, 32, width of haddr/addr (`AHB_ADDR_WIDTH)
- DATA_WIDTH, 32, width of hwdata/hrdata/wdata/rdata (`AHB_DATA_WIDTH); one of 32 or 64
- clk  in  1  bus clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- hsel  in  1  slave select from decoder
- haddr  in  ADDR_WIDTH  address-phase address
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- hwrite  in  1  1 = write
- hsize  in  3  log2 of bytes per beat
- hburst  in  3  SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16 (0..7)
- hwdata  in  DATA_WIDTH  write data, valid during the data phase
- hready  in  1  bus-level HREADY (all slaves)
- hreadyout  out  1  this slave's ready
- hresp  out  1  0 = OKAY, 1 = ERROR
- hrdata  out  DATA_WIDTH  read data, registered
- valid  out  1  local request pending
- addr  out  ADDR_WIDTH  latched beat address
- write  out  1  latched direction
- size  out  3  latched hsize
- burst  out  3  latched hburst
- wdata  out  DATA_WIDTH  equals hwdata while valid
- ready  in  1  local completion; ignored while valid=0
- rdata  in  DATA_WIDTH  read data, sampled when valid&ready
- slave_error  in  1  with ready: complete the beat with ERROR

## Operation
- States: IDLE, ACCESS, ERR1, ERR2. Reset: IDLE, hreadyout=1, hresp=0, hrdata=0, valid=0, addr/write/size/burst=0.
- Sample point: in IDLE or ERR2, when hsel&hready. htrans NONSEQ/SEQ = beat; IDLE/BUSY = no beat, stay/go IDLE (zero-wait OKAY).
- Beat checks at sample: hsize > log2(DATA_WIDTH/8); haddr not aligned to 2^hsize; SEQ whose haddr differs from the expected next address; SEQ with no open burst. Any failure -> ERR1, valid stays 0.
- Expected next address: INCR/INCRx = prev+2^size; WRAPn = (prev & ~(n*2^size-1)) | ((prev+2^size) & (n*2^size-1)). Burst opens on NONSEQ, closes on NONSEQ/IDLE, on the last beat of fixed-length bursts (beat counter), or on ERROR.
- Passing beat -> ACCESS: latch addr/write/size/burst, valid=1, hreadyout=0.
- ACCESS: wait for ready. ready&!slave_error -> IDLE, hreadyout=1, hresp=0, reads load hrdata<=rdata. ready&slave_error -> ERR1.
- ERR1: hresp=1, hreadyout=0. ERR2: hresp=1, hreadyout=1. A beat sampled in ERR2 is accepted normally; otherwise IDLE.
- hrdata holds its value except on read completion.

## Timing
- Minimum data phase: 2 cycles (1 wait state, ACCESS then IDLE) with ready=1 on the first ACCESS cycle; each extra ready=0 cycle adds one.
- valid rises the cycle after the sampling edge, falls the edge after ready; addr/control stable while valid.
- hreadyout, hresp, hrdata registered; no combinational path from ready to hreadyout.
- Back-to-back: the next beat's address phase is sampled on the same edge that completes the current data phase.
- ERROR is always exactly 2 cycles, first with hreadyout=0.
- rst on any cycle (incl. mid-ACCESS or ERR1): next cycle is reset state; pending local request dropped, burst closed.

## Structure
- Shared package ahb_pkg: htrans/hburst/hsize enums, state enum, helper returning burst length (1/4/8/16, 0 = INCR).
- Sub-module ahb_burst_addr: combinational expected-next-address and wrap-mask from prev addr, hsize, hburst.

## Test plan
- Single write NONSEQ 0x100, word, 0xDEADBEEF, ready after 2 cycles -> valid with addr 0x100, write=1, wdata 0xDEADBEEF; hreadyout low 3 cycles, then high with hresp=0.
- INCR4 word read from 0x20, ready=1 immediately, rdata 1,2,3,4 -> addrs 0x20,0x24,0x28,0x2C; hrdata 1..4, one wait state per beat.
- WRAP4 word from 0x38 -> addrs 0x38,0x3C,0x30,0x34; repeat with second SEQ at 0x40 -> 2-cycle ERROR, no valid for that beat.
- Write 0x200 with ready=1, slave_error=1 -> hresp=1/hreadyout=0, then hresp=1/hreadyout=1, then IDLE OKAY.
- Halfword at 0x101, and hsize=3 with DATA_WIDTH=32 -> ERROR, valid never asserted.
- rst during ACCESS with ready=0 -> next cycle valid=0, hreadyout=1, hresp=0; new NONSEQ 0x0 accepted after.
